mem_loader: RTL and testbench

- Host-side bridge that drives the processor's external memory-control and pause inputs from a byte stream, normally the output of a UART receiver.
- Decodes byte commands (pause, run, write word, read word) and performs single-word memory accesses while the processor is halted.
- Returns read data and acknowledges as a byte stream to a UART transmitter.
- Sits between the serial front end and the processor's external ports.

---
 rtl/mem_loader_pkg.sv | 25 ++
 rtl/mem_loader.sv | 170 +++++++++++++++++
 tb/tb_mem_loader.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_loader_pkg.sv
// Shared encodings for the host memory loader: memory access modes,
// command/response bytes and the loader FSM state type.
package mem_loader_pkg;

  localparam logic [2:0] MEM_NONE = 3'd0;
  localparam logic [2:0] MEM_BYTE = 3'd1;
  localparam logic [2:0] MEM_HALF = 3'd2;
  localparam logic [2:0] MEM_WORD = 3'd3;

  localparam logic [7:0] CMD_PAUSE = 8'h50;
  localparam logic [7:0] CMD_GO    = 8'h47;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'h4B;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_ACCESS,
    ST_RELEASE,
    ST_SEND
  } ld_state_e;

endpackage

// File: rtl/mem_loader.sv
// Byte-command bridge from a UART stream to the processor's external memory
// port and pause input; replies (ACK or read data) go out as a byte stream.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        proc_run,
  output logic        ext_control,
  output logic [31:0] ext_address,
  output logic [31:0] ext_data,
  output logic [2:0]  ext_read_mode,
  output logic [2:0]  ext_write_mode,
  input  logic [31:0] ext_read_data,
  output logic        busy
);

  localparam int AW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  ld_state_e       state_q, state_d;
  logic            cmd_wr_q, cmd_wr_d;
  logic            proc_run_q, proc_run_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [AW-1:0]   acc_cnt_q, acc_cnt_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic [31:0]     rd_q, rd_d;
  logic [31:0]     tx_sr_q, tx_sr_d;
  logic [2:0]      tx_left_q, tx_left_d;

  logic rx_fire, tx_fire, timed_out;

  assign rx_ready = !rst && (state_q == ST_IDLE || state_q == ST_GET_ADDR ||
                             state_q == ST_GET_DATA);
  assign rx_fire  = rx_valid && rx_ready;
  assign tx_valid = (state_q == ST_SEND);
  assign tx_fire  = tx_valid && tx_ready;
  assign tx_data  = tx_sr_q[31:24];

  assign proc_run       = proc_run_q;
  assign ext_control    = (state_q == ST_ACCESS) || (state_q == ST_RELEASE);
  assign ext_address    = addr_q;
  assign ext_data       = data_q;
  assign ext_write_mode = (state_q == ST_ACCESS && cmd_wr_q)  ? MEM_WORD : MEM_NONE;
  assign ext_read_mode  = (state_q == ST_ACCESS && !cmd_wr_q) ? MEM_WORD : MEM_NONE;
  assign busy           = (state_q != ST_IDLE);

  assign timed_out = (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    cmd_wr_d   = cmd_wr_q;
    proc_run_d = proc_run_q;
    byte_cnt_d = byte_cnt_q;
    acc_cnt_d  = acc_cnt_q;
    to_cnt_d   = to_cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rd_d       = rd_q;
    tx_sr_d    = tx_sr_q;
    tx_left_d  = tx_left_q;

    case (state_q)
      ST_IDLE: begin
        if (rx_fire) begin
          case (rx_data)
            CMD_PAUSE, CMD_GO: begin
              proc_run_d = (rx_data == CMD_GO);
              tx_sr_d    = {RSP_ACK, 24'h0};
              tx_left_d  = 3'd1;
              state_d    = ST_SEND;
            end
            CMD_WRITE, CMD_READ: begin
              proc_run_d = 1'b0;
              cmd_wr_d   = (rx_data == CMD_WRITE);
              byte_cnt_d = 2'd0;
              to_cnt_d   = '0;
              state_d    = ST_GET_ADDR;
            end
            default: ;
          endcase
        end
      end

      ST_GET_ADDR, ST_GET_DATA: begin
        if (rx_fire) begin
          to_cnt_d   = '0;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (state_q == ST_GET_ADDR) addr_d = {addr_q[23:0], rx_data};
          else                        data_d = {data_q[23:0], rx_data};
          if (byte_cnt_q == 2'd3) begin
            acc_cnt_d = '0;
            state_d   = (state_q == ST_GET_ADDR && cmd_wr_q) ? ST_GET_DATA : ST_ACCESS;
          end
        end else if (timed_out) begin
          to_cnt_d = '0;
          state_d  = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      ST_ACCESS: begin
        acc_cnt_d = acc_cnt_q + 1'b1;
        if (acc_cnt_q == AW'(ACCESS_CYCLES - 1)) begin
          // Sample read data at the end of the hold window, once memory has settled.
          if (!cmd_wr_q) rd_d = ext_read_data;
          acc_cnt_d = '0;
          state_d   = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        tx_sr_d   = cmd_wr_q ? {RSP_ACK, 24'h0} : rd_q;
        tx_left_d = cmd_wr_q ? 3'd1 : 3'd4;
        state_d   = ST_SEND;
      end

      ST_SEND: begin
        if (tx_fire) begin
          tx_sr_d   = {tx_sr_q[23:0], 8'h00};
          tx_left_d = tx_left_q - 3'd1;
          if (tx_left_q == 3'd1) state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cmd_wr_q   <= 1'b0;
      proc_run_q <= 1'b0;
      byte_cnt_q <= '0;
      acc_cnt_q  <= '0;
      to_cnt_q   <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      rd_q       <= '0;
      tx_sr_q    <= '0;
      tx_left_q  <= '0;
    end else begin
      state_q    <= state_d;
      cmd_wr_q   <= cmd_wr_d;
      proc_run_q <= proc_run_d;
      byte_cnt_q <= byte_cnt_d;
      acc_cnt_q  <= acc_cnt_d;
      to_cnt_q   <= to_cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rd_q       <= rd_d;
      tx_sr_q    <= tx_sr_d;
      tx_left_q  <= tx_left_d;
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: expected tx bytes go into a queue when a
// command is issued; a negedge monitor pops and compares each transferred byte.
module tb_mem_loader;
  import mem_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        proc_run;
  logic        ext_control;
  logic [31:0] ext_address;
  logic [31:0] ext_data;
  logic [2:0]  ext_read_mode;
  logic [2:0]  ext_write_mode;
  logic [31:0] ext_read_data;
  logic        busy;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int ctl_cycles = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_byte;

  mem_loader #(.ACCESS_CYCLES(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .proc_run(proc_run), .ext_control(ext_control),
    .ext_address(ext_address), .ext_data(ext_data),
    .ext_read_mode(ext_read_mode), .ext_write_mode(ext_write_mode),
    .ext_read_data(ext_read_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  // Scoreboard monitor: every transferred tx byte must match the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      if (ext_control) ctl_cycles++;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL tx_unexpected: actual=%h required=no byte", tx_data);
        end else begin
          exp_byte = exp_q.pop_front();
          chk("tx_byte", {24'h0, tx_data}, {24'h0, exp_byte});
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (rx_ready) begin
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    chk_cnt++;
    $display("FAIL send_byte_timeout: rx_ready=0 for 200 cycles, byte %h", b);
    rx_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] c, input logic [31:0] a);
    send_byte(c);
    for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) return;
    end
    chk_cnt++;
    $display("FAIL drain_timeout: actual=%0d bytes pending busy=%b required=0 pending idle",
             exp_q.size(), busy);
  endtask

  // Called right after the last command byte is accepted; follows the access
  // cycle by cycle. Read data is only valid on the final access clock.
  task automatic check_access(input bit wr, input logic [31:0] addr,
                              input logic [31:0] wdat, input logic [31:0] rdv);
    int n = 0;
    bit other_bad = 0;
    bit bus_bad = 0;
    if (!wr) ext_read_data = 32'h0BAD0BAD;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ext_control && ((wr ? ext_write_mode : ext_read_mode) == MEM_WORD)) begin
        n++;
        if ((wr ? ext_read_mode : ext_write_mode) != MEM_NONE) other_bad = 1;
        if (ext_address !== addr || (wr && ext_data !== wdat)) bus_bad = 1;
        if (!wr) ext_read_data = (n == 4) ? rdv : 32'h0BAD0BAD;
      end else begin
        break;
      end
    end
    chk(wr ? "wr_access_cycles" : "rd_access_cycles", n, 4);
    chk("access_other_mode_idle", {31'h0, other_bad}, 0);
    chk("access_addr_data", {31'h0, bus_bad}, 0);
    chk("release_cycle", {24'h0, ext_control, ext_read_mode, ext_write_mode, tx_valid},
        {24'h0, 1'b1, 3'd0, 3'd0, 1'b0});
    @(negedge clk);
    chk("ctl_fall_tx_rise", {30'h0, ext_control, tx_valid}, 32'h1);
  endtask

  initial begin
    int base;
    int stall_bad;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1; ext_read_data = '0;

    // 1: reset state, then 'G' and 'P'
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl", {24'h0, rx_ready, tx_valid, busy, proc_run, ext_control,
                    ext_read_mode == MEM_NONE, ext_write_mode == MEM_NONE, 1'b0}, 32'h6);
    chk("rst_address", ext_address, 0);
    chk("rst_data", ext_data, 0);
    chk("rst_tx_data", {24'h0, tx_data}, 0);
    @(negedge clk);
    rst = 1'b0;

    exp_q.push_back(RSP_ACK);
    send_byte(CMD_GO);
    chk("go_proc_run", {31'h0, proc_run}, 1);
    drain();
    exp_q.push_back(RSP_ACK);
    send_byte(CMD_PAUSE);
    chk("pause_proc_run", {31'h0, proc_run}, 0);
    drain();

    // 2: word write while running
    exp_q.push_back(RSP_ACK);
    send_byte(CMD_GO);
    drain();
    exp_q.push_back(RSP_ACK);
    send_byte(CMD_WRITE);
    chk("write_halts_proc", {31'h0, proc_run}, 0);
    for (int i = 3; i >= 0; i--) send_byte(8'(32'h00000100 >> (i*8)));
    for (int i = 3; i >= 0; i--) send_byte(8'(32'hDEADBEEF >> (i*8)));
    check_access(1, 32'h00000100, 32'hDEADBEEF, 0);
    drain();
    chk("addr_held", ext_address, 32'h00000100);
    chk("data_held", ext_data, 32'hDEADBEEF);

    // 3: word read
    exp_q.push_back(8'hCA); exp_q.push_back(8'hFE);
    exp_q.push_back(8'hF0); exp_q.push_back(8'h0D);
    send_cmd(CMD_READ, 32'h00000100);
    check_access(0, 32'h00000100, 0, 32'hCAFEF00D);
    drain();

    // 4: read response stalled by the transmitter
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
    exp_q.push_back(8'hCA); exp_q.push_back(8'hFE);
    exp_q.push_back(8'hF0); exp_q.push_back(8'h0D);
    send_cmd(CMD_READ, 32'h00000100);
    check_access(0, 32'h00000100, 0, 32'hCAFEF00D);
    stall_bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!(tx_valid && tx_data == 8'hCA && !rx_ready)) stall_bad++;
    end
    chk("stall_hold_cycles_bad", stall_bad, 0);
    @(posedge clk);
    #1;
    tx_ready = 1'b1;
    drain();

    // 5: inter-byte timeout (TIMEOUT_CYCLES=16)
    base = ctl_cycles;
    send_byte(CMD_WRITE);
    send_byte(8'h00);
    send_byte(8'h00);
    repeat (12) @(posedge clk);
    #1;
    chk("timeout_not_early", {31'h0, busy}, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("timeout_idle", {31'h0, busy}, 0);
    chk("timeout_no_access", ctl_cycles - base, 0);
    exp_q.push_back(RSP_ACK);
    send_byte(CMD_GO);
    drain();

    // 6: reset during access, then an unknown byte
    send_cmd(CMD_WRITE, 32'h00000200);
    for (int i = 3; i >= 0; i--) send_byte(8'(32'h11223344 >> (i*8)));
    @(negedge clk);
    chk("access_before_rst", {31'h0, ext_control}, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_abandon", {24'h0, ext_control, ext_read_mode, ext_write_mode, tx_valid},
        0);
    chk("rst_abandon_busy", {31'h0, busy}, 0);
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'h41);
    repeat (20) @(negedge clk);
    chk("unknown_byte_idle", {31'h0, busy}, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
